// File: rtl/tron_video_pkg.sv
// tron_video_pkg: shared video timing constants, fetch FSM state type and the scanline address helper
package tron_video_pkg;
    localparam int WORDS_PER_LINE = 160;
    localparam int LINES          = 480;
    localparam int PIX_PER_WORD   = 4;
    localparam int H_VISIBLE      = 640;
    typedef enum logic {IDLE, FETCH} fetch_state_t;
    // line*160 as two shifts so no multiplier is inferred
    function automatic logic [19:0] line_offset(input logic [8:0] line);
        logic [19:0] l;
        l = {11'd0, line};
        return (l << 7) + (l << 5);
    endfunction
endpackage

// File: rtl/line_buffer_2bank.sv
// line_buffer_2bank: two-bank scanline buffer with one synchronous write port and one synchronous read port
//   Clk                  : clock, both ports on posedge
//   wbank/waddr/wdata/we : write port, writes wdata into bank wbank at waddr when we=1
//   rbank/raddr          : read port address, rdata valid one cycle later
//   rdata                : registered read data
module line_buffer_2bank #(
    parameter int DEPTH = 160,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          we,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [15:0] mem [2][DEPTH];

    // no reset so the array maps onto block RAM
    always_ff @(posedge Clk) begin
        if (we)
            mem[wbank][waddr] <= wdata;
        rdata <= mem[rbank][raddr];
    end
endmodule

// File: rtl/sram_line_fetcher.sv
// sram_line_fetcher: fetches the next scanline from SRAM into a ping-pong buffer and serves palette indices
//   Clk, Reset          : clock and asynchronous active-low reset
//   line_start/next_line: hblank pulse and the line number to fetch
//   mem_req/mem_addr    : registered read request to the SRAM controller, held until mem_ack
//   mem_ack/mem_rdata   : read completion and data
//   draw_x/pix_idx      : display column in, 4-bit palette index out
//   fetch_busy          : fetch in progress
//   underrun            : pulse when a new line starts before the previous fetch finished
import tron_video_pkg::*;

module sram_line_fetcher #(
    parameter int          WORDS_PER_LINE = tron_video_pkg::WORDS_PER_LINE,
    parameter int          LINES          = tron_video_pkg::LINES,
    parameter logic [19:0] BASE_ADDR      = 20'h00000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [8:0]  next_line,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [9:0]  draw_x,
    output logic [3:0]  pix_idx,
    output logic        fetch_busy,
    output logic        underrun
);
    localparam int AW = $clog2(WORDS_PER_LINE);

    fetch_state_t  state;
    logic          disp_bank;
    logic [AW-1:0] count;
    logic [19:0]   base;
    logic [19:0]   new_base;
    logic          line_ok;
    logic          wr_en;
    logic [15:0]   rd_word;
    logic [1:0]    sel_q;
    logic          vis_q;

    assign line_ok    = int'(next_line) < LINES;
    assign new_base   = BASE_ADDR + line_offset(next_line);
    assign fetch_busy = state == FETCH;
    // uses the pre-swap fill bank, so an ack coinciding with line_start lands in the old line
    assign wr_en      = state == FETCH && mem_ack;

    line_buffer_2bank #(.DEPTH(WORDS_PER_LINE), .AW(AW)) u_buf (
        .Clk   (Clk),
        .wbank (~disp_bank),
        .waddr (count),
        .wdata (mem_rdata),
        .we    (wr_en),
        .rbank (disp_bank),
        .raddr (AW'(draw_x >> 2)),
        .rdata (rd_word)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            disp_bank <= 1'b0;
            count     <= '0;
            base      <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= line_start && state == FETCH;
            if (line_start) begin
                if (line_ok) begin
                    disp_bank <= ~disp_bank;
                    base      <= new_base;
                    count     <= '0;
                    state     <= FETCH;
                    mem_req   <= 1'b1;
                    mem_addr  <= new_base;
                end else begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            end else if (wr_en) begin
                if (count == AW'(WORDS_PER_LINE - 1)) begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end else begin
                    count    <= count + 1'b1;
                    mem_addr <= base + 20'(count) + 20'd1;
                end
            end
        end
    end

    // second stage: pick the nibble from the word read one cycle earlier
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sel_q   <= 2'd0;
            vis_q   <= 1'b0;
            pix_idx <= 4'd0;
        end else begin
            sel_q   <= draw_x[1:0];
            vis_q   <= int'(draw_x) < H_VISIBLE;
            pix_idx <= vis_q ? rd_word[{sel_q, 2'b00} +: 4] : 4'd0;
        end
    end
endmodule

// File: tb/tb_sram_line_fetcher.sv
// tb_sram_line_fetcher: randomized self-checking bench with an SRAM responder and a line-buffer model
module tb_sram_line_fetcher;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        line_start = 1'b0;
    logic [8:0]  next_line = '0;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [9:0]  draw_x = 10'd700;
    logic [3:0]  pix_idx;
    logic        fetch_busy;
    logic        underrun;

    int checks = 0;
    int fails = 0;

    logic [15:0] model_buf [2][160];
    bit          model_disp = 1'b0;
    bit          model_busy = 1'b0;

    sram_line_fetcher dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_line  (next_line),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .draw_x     (draw_x),
        .pix_idx    (pix_idx),
        .fetch_busy (fetch_busy),
        .underrun   (underrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] exp_pix(input int x);
        if (x >= 640)
            return 4'd0;
        return 4'((model_buf[model_disp][x / 4] >> (4 * (x % 4))) & 16'hF);
    endfunction

    // called at a negedge; returns at the following negedge with line_start low
    task automatic start_line(input int line);
        bit exp_ur;
        bit ok;
        exp_ur = model_busy;
        ok = line < 480;
        line_start = 1'b1;
        next_line = 9'(line);
        if (ok) model_disp = ~model_disp;
        model_busy = ok;
        @(negedge Clk);
        line_start = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (underrun !== exp_ur) begin
            fails++;
            $display("FAIL start_underrun line=%0d got %b want %b", line, underrun, exp_ur);
        end
        checks++;
        if (mem_req !== ok || fetch_busy !== ok) begin
            fails++;
            $display("FAIL start_req line=%0d got req=%b busy=%b want %b", line, mem_req, fetch_busy, ok);
        end
        if (ok) begin
            checks++;
            if (mem_addr !== 20'(line * 160)) begin
                fails++;
                $display("FAIL start_addr line=%0d got %h want %h", line, mem_addr, 20'(line * 160));
            end
        end
    endtask

    // SRAM responder: acks every gap-th cycle, checking the request each cycle
    task automatic serve(input int line, input int n, input int gap, input bit use_pat, input logic [15:0] pat);
        int k = 0;
        int c = 0;
        int f;
        logic [15:0] d;
        f = model_disp ? 0 : 1;
        while (k < n && c < 2000) begin
            checks++;
            if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== 20'(line * 160 + k)) begin
                fails++;
                $display("FAIL serve_req line=%0d word=%0d got req=%b busy=%b addr=%h want req=1 busy=1 addr=%h",
                         line, k, mem_req, fetch_busy, mem_addr, 20'(line * 160 + k));
            end
            if (c >= 1) begin
                checks++;
                if (underrun !== 1'b0) begin
                    fails++;
                    $display("FAIL serve_underrun line=%0d cycle=%0d got %b want 0", line, c, underrun);
                end
            end
            if (c % gap == gap - 1) begin
                d = use_pat ? pat : 16'($urandom);
                mem_ack = 1'b1;
                mem_rdata = d;
                model_buf[f][k] = d;
                k++;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 16'($urandom);
            end
            c++;
            @(negedge Clk);
        end
        mem_ack = 1'b0;
        checks++;
        if (k != n) begin
            fails++;
            $display("FAIL serve_timeout line=%0d got %0d acks want %0d", line, k, n);
        end
        if (n == 160) begin
            model_busy = 1'b0;
            checks++;
            if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
                fails++;
                $display("FAIL serve_done line=%0d got req=%b busy=%b want 0 0", line, mem_req, fetch_busy);
            end
        end
    endtask

    // value for draw_x driven before edge n shows at the negedge after edge n+1
    task automatic sweep(input int xs[$]);
        int i;
        for (i = 0; i < xs.size() + 2; i++) begin
            if (i >= 2) begin
                checks++;
                if (pix_idx !== exp_pix(xs[i - 2])) begin
                    fails++;
                    $display("FAIL pix x=%0d got %h want %h", xs[i - 2], pix_idx, exp_pix(xs[i - 2]));
                end
            end
            if (i < xs.size()) draw_x = 10'(xs[i]);
            @(negedge Clk);
        end
        draw_x = 10'd700;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge Clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 20'd0 || pix_idx !== 4'd0 || fetch_busy !== 1'b0 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals got req=%b addr=%h pix=%h busy=%b ur=%b want all 0",
                     mem_req, mem_addr, pix_idx, fetch_busy, underrun);
        end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_line0;
        start_line(0);
        serve(0, 160, 2, 1'b0, 16'h0);
    endtask

    task automatic test_line479;
        start_line(479);
        serve(479, 160, 1, 1'b0, 16'h0);
    endtask

    task automatic test_random_pixels;
        int xs[$];
        repeat (40) xs.push_back(int'($urandom_range(0, 700)));
        xs.push_back(639);
        xs.push_back(640);
        sweep(xs);
    endtask

    task automatic test_pattern;
        int xs[$];
        start_line(2);
        serve(2, 160, int'($urandom_range(1, 3)), 1'b1, 16'h3210);
        start_line(3);
        for (int i = 0; i < 8; i++) xs.push_back(i);
        xs.push_back(636);
        xs.push_back(1000);
        sweep(xs);
        serve(3, 160, 2, 1'b0, 16'h0);
    endtask

    task automatic test_invalid_line;
        int xs[$];
        start_line(480);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || underrun !== 1'b0) begin
                fails++;
                $display("FAIL invalid_line got req=%b busy=%b ur=%b want 0 0 0", mem_req, fetch_busy, underrun);
            end
            @(negedge Clk);
        end
        for (int i = 0; i < 8; i++) xs.push_back(i);
        sweep(xs);
    endtask

    task automatic test_underrun;
        int xs[$];
        logic [15:0] d;
        start_line(100);
        serve(100, 50, 2, 1'b0, 16'h0);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'(100 * 160 + 50)) begin
            fails++;
            $display("FAIL underrun_pre got req=%b addr=%h want 1 %h", mem_req, mem_addr, 20'(100 * 160 + 50));
        end
        d = 16'($urandom);
        mem_ack = 1'b1;
        mem_rdata = d;
        model_buf[model_disp ? 0 : 1][50] = d;
        start_line(200);
        serve(200, 160, 2, 1'b0, 16'h0);
        for (int x = 196; x < 208; x++) xs.push_back(x);
        repeat (20) xs.push_back(int'($urandom_range(0, 639)));
        sweep(xs);
    endtask

    task automatic test_reset_mid_fetch;
        start_line(10);
        serve(10, 20, 2, 1'b0, 16'h0);
        #2 Reset = 1'b0;
        #1;
        model_disp = 1'b0;
        model_busy = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got req=%b busy=%b want 0 0", mem_req, fetch_busy);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++;
            if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || pix_idx !== 4'd0) begin
                fails++;
                $display("FAIL after_reset got req=%b busy=%b pix=%h want 0 0 0", mem_req, fetch_busy, pix_idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line0();
        test_line479();
        test_random_pixels();
        test_pattern();
        test_invalid_line();
        test_underrun();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
